// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount pattern generator: FSM states and
// the count-width helper used to size popcount results.
package popcount_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int cw_f(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/popcount_w.sv
// Combinational popcount of a WIDTH-bit vector into a CW-bit count.
module popcount_w
   import popcount_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int CW    = cw_f(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [CW-1:0]    cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/popcount3_pattern_gen.sv
// Inverse popcount: for a requested weight k, scans candidates upward one per
// cycle and presents every WIDTH-bit pattern of weight k in ascending order.
module popcount3_pattern_gen
   import popcount_pkg::*;
#(
   parameter  int WIDTH = 3,
   localparam int CW    = cw_f(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pattern,
   output logic             out_last,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONES = '1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CW-1:0]    k_q, k_d;
   logic             err_q, err_d;

   logic [CW-1:0]    cand_cnt;
   logic [WIDTH-1:0] last_pat;
   logic             match, at_last, accept, in_range;

   popcount_w #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_popcount (
      .vec_i (cand_q),
      .cnt_o (cand_cnt)
   );

   // Largest pattern of weight k: k ones packed into the top bits.
   assign last_pat = ~(ONES >> k_q);
   assign in_range = ({1'b0, in_count} <= (CW + 1)'(WIDTH));

   assign match    = (state_q == RUN) && (cand_cnt == k_q);
   assign at_last  = match && (cand_q == last_pat);
   assign in_ready = (state_q == IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   assign out_valid   = match;
   assign out_last    = at_last;
   assign out_pattern = cand_q;
   assign err         = err_q;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      k_d     = k_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_range) begin
                  state_d = RUN;
                  cand_d  = '0;
                  k_d     = in_count;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Non-matching candidates are skipped; a match waits for the consumer.
            if (!match || out_ready) begin
               cand_d = cand_q + WIDTH'(1);
               if (at_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cand_q  <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         k_q     <= k_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/popcount3_pattern_gen.md
POPCOUNT3_PATTERN_GEN -- requirements
Module: popcount3_pattern_gen

Interface
REQ-001 Parameter: WIDTH, default 3, pattern width in bits.
REQ-002 Derived constant: CW = $clog2(WIDTH+1), count width; 2 for the default.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  request carries a target weight.
REQ-006 Port: in_ready  output  1  block idle, request accepted when in_valid && in_ready.
REQ-007 Port: in_count  input  CW  target popcount k.
REQ-008 Port: out_valid  output  1  out_pattern holds a pattern of weight k.
REQ-009 Port: out_ready  input  1  consumer accepts the pattern when out_valid && out_ready.
REQ-010 Port: out_pattern  output  WIDTH  enumerated pattern.
REQ-011 Port: out_last  output  1  current pattern is the final one for this request.
REQ-012 Port: err  output  1  one-cycle pulse: request rejected because in_count > WIDTH.

Function
REQ-013 The block is the inverse of a popcount. For an accepted k, it emits every WIDTH-bit pattern with popcount k, exactly once, in ascending numeric order.
REQ-014 The block has two FSM states, IDLE and RUN.
- in_ready = 1 only in IDLE with rst low.
- Transition IDLE->RUN on acceptance with in_count <= WIDTH; k is latched and the candidate register cand is set to 0.
REQ-015 On acceptance with in_count > WIDTH:
- the FSM stays in IDLE;
- err = 1 for exactly the following cycle;
- no output is produced.
REQ-016 In RUN, out_pattern = cand and out_valid = (popcount(cand) == k); both are driven from registers only.
REQ-017 In RUN, cand increments by 1 per cycle when it does not match, or when it matches and out_ready = 1. cand holds when it matches and out_ready = 0.
REQ-018 While out_valid = 1 and out_ready = 0, out_pattern and out_last are held stable.
REQ-019 out_last = out_valid && (cand == the k ones in the top k bits); for k = 0, this is the pattern all zeros.
REQ-020 When the out_last pattern is accepted, the FSM returns to IDLE and in_ready = 1 on the next cycle.
- A new request accepted on that cycle starts with cand = 0.
REQ-021 First output latency: for k = 0 the first pattern is valid the cycle after acceptance. For other k, the first pattern appears when the scan reaches the first matching value; one candidate is examined per cycle.
REQ-022 in_valid and in_count are ignored in RUN.
REQ-023 The number of patterns emitted for k equals C(WIDTH, k): 1, 3, 3, 1 for the default width.

Reset
REQ-024 While rst is high, at the next edge:
- the FSM goes to IDLE;
- cand and k are cleared to 0;
- out_valid, out_last and err are 0;
- in_ready is 0 while rst is high.
REQ-025 Reset asserted in RUN aborts the request immediately. No further patterns are emitted, and in_ready = 1 the first cycle after rst falls.

Structure
REQ-026 A shared package popcount_pkg holds the FSM state enum (IDLE, RUN) and the CW width function.
REQ-027 The match test instantiates one sub-module, popcount_w: a parameterised combinational popcount of WIDTH bits to CW bits.

Verification
REQ-028 Weight 2, out_ready tied 1: in_count = 2 accepted.
- Required: out_pattern 011, 101, 110 on consecutive valid beats.
- out_last = 1 only on 110.
- in_ready = 1 the cycle after the 110 beat.
REQ-029 Weights 0 and 3, back to back.
- k = 0 -> a single beat 000 with out_last = 1.
- k = 3 -> a single beat 111 with out_last = 1.
- No extra beats in either case.
REQ-030 Weight 1 with out_ready held 0 for 4 cycles on beat 010.
- Required: out_pattern stays 010 with out_valid = 1 throughout the stall.
- Then 100 follows with out_last = 1.
REQ-031 Request while busy: in_valid = 1, in_count = 3 asserted during a k = 1 run.
- Required: in_ready = 0 for the whole run and the request is ignored.
- After the run, the held request is accepted and yields 111.
REQ-032 Reset mid-run: rst pulsed after the first beat (001) of k = 1.
- Required: out_valid = 0 from the next cycle, in_ready = 1 after rst falls.
- A new k = 2 request then produces 011, 101, 110.
REQ-033 Out-of-range count, with WIDTH = 4 (CW = 3): in_count = 5 accepted.
- Required: err = 1 for one cycle, no out_valid, and the FSM remains in IDLE.
